// File: rtl/orv64_func_pkg.sv
// orv64_func_pkg: shared instruction helper functions
package orv64_func_pkg;
  function automatic logic func_is_rvc(input logic [15:0] hw);
    return (hw & 16'h0003) != 16'h0003;
  endfunction
endpackage

// File: rtl/orv64_typedef_pkg.sv
// orv64_typedef_pkg: shared fetch/decode datapath types
package orv64_typedef_pkg;
  localparam int ORV64_VADDR_W = 39;
  typedef struct packed {
    logic [31:0]              inst;
    logic [ORV64_VADDR_W-1:0] pc;
    logic                     is_rvc;
  } orv64_if_realign_out_t;
endpackage

// File: rtl/orv64_if_realign.sv
// orv64_if_realign: realigns 32-bit fetch parcels into whole base/RVC instructions
module orv64_if_realign
  import orv64_typedef_pkg::*;
  import orv64_func_pkg::*;
#(
  parameter int VADDR_W = ORV64_VADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [VADDR_W-1:0] flush_pc,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic [31:0]        fetch_data,
  input  logic [VADDR_W-1:0] fetch_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_inst,
  output logic [VADDR_W-1:0] out_pc,
  output logic               out_is_rvc
);
  orv64_if_realign_out_t r_out, w_nxt;
  logic               r_out_valid, r_lo_vld, r_skip_lo;
  logic [15:0]        r_lo_q;
  logic [VADDR_W-1:0] r_lo_pc;
  logic [15:0]        w_hw0, w_hw1;
  logic [VADDR_W-1:0] w_pc2;
  logic w_slot_free, w_lo_rvc, w_hw0_rvc, w_hw1_rvc, w_acc, w_emit, w_lo_ld, w_lo_clr;
  logic w_unused;
  assign w_unused    = ^{flush_pc[VADDR_W-1:2], flush_pc[0]};
  assign w_hw0       = fetch_data[15:0];
  assign w_hw1       = fetch_data[31:16];
  assign w_pc2       = fetch_pc + VADDR_W'(2);
  assign w_slot_free = ~r_out_valid | out_ready;
  assign w_lo_rvc    = func_is_rvc(r_lo_q);
  assign w_hw0_rvc   = func_is_rvc(w_hw0);
  assign w_hw1_rvc   = func_is_rvc(w_hw1);
  // a buffered RVC leftover drains without consuming a parcel
  assign fetch_ready = ~flush & w_slot_free & ~(r_lo_vld & w_lo_rvc);
  assign w_acc       = fetch_valid & fetch_ready;
  assign w_emit      = r_lo_vld ? (w_lo_rvc ? w_slot_free : w_acc)
                                : w_acc & (~r_skip_lo | w_hw1_rvc);
  assign w_nxt.inst  = r_lo_vld  ? (w_lo_rvc ? {16'b0, r_lo_q} : {w_hw0, r_lo_q})
                     : r_skip_lo ? {16'b0, w_hw1}
                     : w_hw0_rvc ? {16'b0, w_hw0} : fetch_data;
  assign w_nxt.pc     = r_lo_vld ? r_lo_pc : r_skip_lo ? w_pc2 : fetch_pc;
  assign w_nxt.is_rvc = r_lo_vld ? w_lo_rvc : r_skip_lo | w_hw0_rvc;
  assign w_lo_ld  = w_acc & (r_lo_vld | (r_skip_lo ? ~w_hw1_rvc : w_hw0_rvc));
  assign w_lo_clr = r_lo_vld & w_lo_rvc & w_slot_free;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_lo_vld    <= 1'b0;
      r_lo_q      <= '0;
      r_lo_pc     <= '0;
      r_skip_lo   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_lo_vld    <= 1'b0;
      r_skip_lo   <= flush_pc[1];
    end else begin
      if (w_slot_free) r_out_valid <= w_emit;
      if (w_slot_free && w_emit) r_out <= w_nxt;
      if (w_lo_ld) begin
        r_lo_vld <= 1'b1;
        r_lo_q   <= w_hw1;
        r_lo_pc  <= w_pc2;
      end else if (w_lo_clr) r_lo_vld <= 1'b0;
      if (w_acc && !r_lo_vld) r_skip_lo <= 1'b0;
    end
  end
  assign out_valid  = r_out_valid;
  assign out_inst   = r_out.inst;
  assign out_pc     = r_out.pc;
  assign out_is_rvc = r_out.is_rvc;
endmodule

// File: tb/tb_orv64_if_realign.sv
// tb_orv64_if_realign: directed scenarios for the fetch realigner
module tb_orv64_if_realign;
  localparam int VW = 39;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [VW-1:0] flush_pc = '0;
  logic          fetch_valid = 1'b0;
  logic          fetch_ready;
  logic [31:0]   fetch_data = '0;
  logic [VW-1:0] fetch_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_inst;
  logic [VW-1:0] out_pc;
  logic          out_is_rvc;
  int n_chk = 0;
  int n_fail = 0;
  orv64_if_realign dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_data(fetch_data), .fetch_pc(fetch_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_is_rvc(out_is_rvc)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] d, input logic [VW-1:0] pc);
    fetch_valid = v;
    fetch_data  = d;
    fetch_pc    = pc;
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_chk++;
    if ({out_valid, out_is_rvc, out_inst, out_pc} !== {1'b0, 1'b0, 32'h0, 39'h0}) begin
      n_fail++;
      $display("FAIL reset: got v=%b rvc=%b inst=%h pc=%h, want all zero", out_valid, out_is_rvc, out_inst, out_pc);
    end
  endtask
  task automatic test_full;
    drive(1'b1, 32'h00A00093, 39'h1000);
    n_chk++;
    if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready: got %b want 1", fetch_ready); end
    tick();
    drive(1'b0, 32'h0, 39'h0);
    n_chk++;
    if ({out_valid, out_is_rvc, out_inst, out_pc} !== {1'b1, 1'b0, 32'h00A00093, 39'h1000}) begin
      n_fail++;
      $display("FAIL full_out: got v=%b rvc=%b inst=%h pc=%h, want 1 0 00a00093 1000", out_valid, out_is_rvc, out_inst, out_pc);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain: out_valid got %b want 0", out_valid); end
  endtask
  task automatic test_two_rvc;
    drive(1'b1, 32'h41014505, 39'h2000);
    tick();
    drive(1'b1, 32'h00A00093, 39'h2004);
    n_chk++;
    if ({out_valid, out_is_rvc, out_inst, out_pc} !== {1'b1, 1'b1, 32'h4505, 39'h2000}) begin
      n_fail++;
      $display("FAIL rvc2_first: got v=%b rvc=%b inst=%h pc=%h, want 1 1 4505 2000", out_valid, out_is_rvc, out_inst, out_pc);
    end
    n_chk++;
    if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL rvc2_stall: fetch_ready got %b want 0", fetch_ready); end
    tick();
    n_chk++;
    if ({out_valid, out_is_rvc, out_inst, out_pc} !== {1'b1, 1'b1, 32'h4101, 39'h2002}) begin
      n_fail++;
      $display("FAIL rvc2_second: got v=%b rvc=%b inst=%h pc=%h, want 1 1 4101 2002", out_valid, out_is_rvc, out_inst, out_pc);
    end
    tick();
    drive(1'b0, 32'h0, 39'h0);
    n_chk++;
    if ({out_valid, out_is_rvc, out_inst, out_pc} !== {1'b1, 1'b0, 32'h00A00093, 39'h2004}) begin
      n_fail++;
      $display("FAIL rvc2_next: got v=%b rvc=%b inst=%h pc=%h, want 1 0 00a00093 2004", out_valid, out_is_rvc, out_inst, out_pc);
    end
    tick();
  endtask
  task automatic test_straddle;
    drive(1'b1, 32'h00934505, 39'h3000);
    tick();
    drive(1'b1, 32'h450500A0, 39'h3004);
    n_chk++;
    if ({out_valid, out_is_rvc, out_inst, out_pc} !== {1'b1, 1'b1, 32'h4505, 39'h3000}) begin
      n_fail++;
      $display("FAIL strad_a: got v=%b rvc=%b inst=%h pc=%h, want 1 1 4505 3000", out_valid, out_is_rvc, out_inst, out_pc);
    end
    n_chk++;
    if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL strad_ready: got %b want 1", fetch_ready); end
    tick();
    drive(1'b0, 32'h0, 39'h0);
    n_chk++;
    if ({out_valid, out_is_rvc, out_inst, out_pc} !== {1'b1, 1'b0, 32'h00A00093, 39'h3002}) begin
      n_fail++;
      $display("FAIL strad_b: got v=%b rvc=%b inst=%h pc=%h, want 1 0 00a00093 3002", out_valid, out_is_rvc, out_inst, out_pc);
    end
    n_chk++;
    if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL strad_lo_rvc_ready: got %b want 0", fetch_ready); end
    tick();
    n_chk++;
    if ({out_valid, out_is_rvc, out_inst, out_pc} !== {1'b1, 1'b1, 32'h4505, 39'h3006}) begin
      n_fail++;
      $display("FAIL strad_c: got v=%b rvc=%b inst=%h pc=%h, want 1 1 4505 3006", out_valid, out_is_rvc, out_inst, out_pc);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL strad_drain: out_valid got %b want 0", out_valid); end
  endtask
  task automatic test_flush_skip;
    flush = 1'b1;
    flush_pc = 39'h4002;
    drive(1'b1, 32'h4505FFFF, 39'h4000);
    n_chk++;
    if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", fetch_ready); end
    tick();
    flush = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    tick();
    drive(1'b0, 32'h0, 39'h0);
    n_chk++;
    if ({out_valid, out_is_rvc, out_inst, out_pc} !== {1'b1, 1'b1, 32'h4505, 39'h4002}) begin
      n_fail++;
      $display("FAIL skip_out: got v=%b rvc=%b inst=%h pc=%h, want 1 1 4505 4002", out_valid, out_is_rvc, out_inst, out_pc);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL skip_single: out_valid got %b want 0", out_valid); end
  endtask
  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(1'b1, 32'h00A00093, 39'h5000);
    tick();
    drive(1'b1, 32'h00B00113, 39'h5004);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({out_valid, out_is_rvc, out_inst, out_pc, fetch_ready} !== {1'b1, 1'b0, 32'h00A00093, 39'h5000, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b rvc=%b inst=%h pc=%h rdy=%b, want 1 0 00a00093 5000 0", i, out_valid, out_is_rvc, out_inst, out_pc, fetch_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", fetch_ready); end
    tick();
    drive(1'b0, 32'h0, 39'h0);
    n_chk++;
    if ({out_valid, out_is_rvc, out_inst, out_pc} !== {1'b1, 1'b0, 32'h00B00113, 39'h5004}) begin
      n_fail++;
      $display("FAIL bp_resume: got v=%b rvc=%b inst=%h pc=%h, want 1 0 00b00113 5004", out_valid, out_is_rvc, out_inst, out_pc);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_nodup: out_valid got %b want 0", out_valid); end
  endtask
  task automatic test_flush_leftover;
    drive(1'b1, 32'h00934505, 39'h6000);
    tick();
    drive(1'b0, 32'h0, 39'h0);
    flush = 1'b1;
    flush_pc = 39'h6000;
    n_chk++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fl_pre: out_valid got %b want 1", out_valid); end
    tick();
    flush = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b want 0", out_valid); end
    drive(1'b1, 32'h00A00093, 39'h6000);
    tick();
    drive(1'b0, 32'h0, 39'h0);
    n_chk++;
    if ({out_valid, out_is_rvc, out_inst, out_pc} !== {1'b1, 1'b0, 32'h00A00093, 39'h6000}) begin
      n_fail++;
      $display("FAIL fl_fresh: got v=%b rvc=%b inst=%h pc=%h, want 1 0 00a00093 6000", out_valid, out_is_rvc, out_inst, out_pc);
    end
    tick();
  endtask
  task automatic test_rst_mid;
    drive(1'b1, 32'h00934505, 39'h7000);
    tick();
    drive(1'b0, 32'h0, 39'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({out_valid, out_is_rvc, out_inst, out_pc} !== {1'b0, 1'b0, 32'h0, 39'h0}) begin
      n_fail++;
      $display("FAIL rst_mid: got v=%b rvc=%b inst=%h pc=%h, want all zero", out_valid, out_is_rvc, out_inst, out_pc);
    end
    drive(1'b1, 32'h00A00093, 39'h7FFFFFFFFC);
    tick();
    drive(1'b0, 32'h0, 39'h0);
    n_chk++;
    if ({out_valid, out_is_rvc, out_inst, out_pc} !== {1'b1, 1'b0, 32'h00A00093, 39'h7FFFFFFFFC}) begin
      n_fail++;
      $display("FAIL rst_fresh: got v=%b rvc=%b inst=%h pc=%h, want 1 0 00a00093 7ffffffffc", out_valid, out_is_rvc, out_inst, out_pc);
    end
    tick();
  endtask
  task automatic test_high_pc;
    drive(1'b1, 32'h41014505, 39'h7FFFFFFFFC);
    tick();
    drive(1'b0, 32'h0, 39'h0);
    tick();
    n_chk++;
    if ({out_valid, out_is_rvc, out_inst, out_pc} !== {1'b1, 1'b1, 32'h4101, 39'h7FFFFFFFFE}) begin
      n_fail++;
      $display("FAIL high_pc: got v=%b rvc=%b inst=%h pc=%h, want 1 1 4101 7ffffffffe", out_valid, out_is_rvc, out_inst, out_pc);
    end
    tick();
  endtask
  initial begin
    test_reset();
    test_full();
    test_two_rvc();
    test_straddle();
    test_flush_skip();
    test_backpressure();
    test_flush_leftover();
    test_rst_mid();
    test_high_pc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
